ps2_input_mapper: RTL and testbench

- Parametrised successor to the fixed keyboard/joystick merge in the emu top level.
- Decodes MiSTer `ps2_key` toggle events through a runtime-writable keymap and merges the result with per-player joystick words.
- Applies selectable SOCD cleaning and per-button autofire.
- Output is one registered button vector per player, consumed by `Main`.

---
 rtl/ps2_input_mapper.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_ps2_input_mapper.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_input_mapper.sv
// ps2_input_mapper: decodes PS/2 key events through a writable keymap, merges
// them with the per-player joystick words, then applies SOCD cleaning and autofire.
module ps2_input_mapper #(
   parameter int unsigned PLAYERS   = 2,
   parameter int unsigned BUTTONS   = 11,
   parameter int unsigned MAP_DEPTH = 32,
   parameter int unsigned AF_PERIOD = 4
) (
   input  logic                         clk_sys,
   input  logic                         RESET,
   input  logic [10:0]                  ps2_key,
   input  logic [PLAYERS*32-1:0]        joy_i,
   input  logic                         map_wr,
   input  logic [$clog2(MAP_DEPTH)-1:0] map_addr,
   input  logic [15:0]                  map_data,
   input  logic [1:0]                   socd_mode,
   input  logic [BUTTONS-1:0]           af_mask,
   input  logic                         af_tick,
   output logic [PLAYERS*BUTTONS-1:0]   buttons_o,
   output logic                         busy,
   output logic                         overflow
);

   localparam int unsigned AW = $clog2(MAP_DEPTH);
   localparam int unsigned NB = PLAYERS * BUTTONS;
   localparam int unsigned CW = (AF_PERIOD > 1) ? $clog2(AF_PERIOD) : 1;

   typedef struct packed {
      logic       valid;
      logic       ext;
      logic [7:0] code;
      logic [1:0] player;
      logic [3:0] button;
   } map_entry_t;

   typedef struct packed {
      logic       pressed;
      logic       ext;
      logic [7:0] code;
   } key_evt_t;

   typedef enum logic [0:0] {S_IDLE, S_SCAN} state_t;

   // Most-recent-edge history codes for last-wins SOCD
   localparam logic [1:0] H_NONE = 2'd0;
   localparam logic [1:0] H_A    = 2'd1;
   localparam logic [1:0] H_B    = 2'd2;

   function automatic map_entry_t mk(input logic ext, input logic [7:0] code,
                                     input logic [1:0] pl, input logic [3:0] btn);
      map_entry_t e;
      e.valid  = 1'b1;
      e.ext    = ext;
      e.code   = code;
      e.player = pl;
      e.button = btn;
      return e;
   endfunction

   // Factory keymap; slot 21 is kept free (P2 has no pause key)
   function automatic map_entry_t default_entry(input int unsigned i);
      map_entry_t e;
      e = '0;
      case (i)
         0:  e = mk(1'b1, 8'h75, 2'd0, 4'd0);
         1:  e = mk(1'b1, 8'h72, 2'd0, 4'd1);
         2:  e = mk(1'b1, 8'h6B, 2'd0, 4'd2);
         3:  e = mk(1'b1, 8'h74, 2'd0, 4'd3);
         4:  e = mk(1'b0, 8'h14, 2'd0, 4'd4);
         5:  e = mk(1'b0, 8'h11, 2'd0, 4'd5);
         6:  e = mk(1'b0, 8'h29, 2'd0, 4'd6);
         7:  e = mk(1'b0, 8'h16, 2'd0, 4'd7);
         8:  e = mk(1'b0, 8'h2E, 2'd0, 4'd8);
         9:  e = mk(1'b0, 8'h4D, 2'd0, 4'd9);
         10: e = mk(1'b0, 8'h46, 2'd0, 4'd10);
         11: e = mk(1'b0, 8'h2D, 2'd1, 4'd0);
         12: e = mk(1'b0, 8'h2B, 2'd1, 4'd1);
         13: e = mk(1'b0, 8'h23, 2'd1, 4'd2);
         14: e = mk(1'b0, 8'h34, 2'd1, 4'd3);
         15: e = mk(1'b0, 8'h1C, 2'd1, 4'd4);
         16: e = mk(1'b0, 8'h1B, 2'd1, 4'd5);
         17: e = mk(1'b0, 8'h15, 2'd1, 4'd6);
         18: e = mk(1'b0, 8'h1E, 2'd1, 4'd7);
         19: e = mk(1'b0, 8'h36, 2'd1, 4'd8);
         20: e = mk(1'b0, 8'h45, 2'd1, 4'd10);
         default: e = '0;
      endcase
      return e;
   endfunction

   // MiSTer joystick bit for button index b (directions are reversed)
   function automatic logic joy_bit(input logic [31:0] j, input int unsigned b);
      logic r;
      case (b)
         0:       r = j[3];
         1:       r = j[2];
         2:       r = j[1];
         3:       r = j[0];
         default: r = (b < 32) ? j[5'(b)] : 1'b0;
      endcase
      return r;
   endfunction

   logic [10:0]       ps2_r;
   logic              tog_prev;
   logic              event_c;
   key_evt_t          new_evt_c;

   state_t            state_q, state_d;
   logic [AW-1:0]     idx_q;
   key_evt_t          ev_q, pend_q;
   logic              pend_valid_q;
   logic              last_c;

   logic              start_new_c, start_pend_c, pend_load_c, pend_clr_c;
   logic              ovf_set_c, commit_c, scan_c;

   map_entry_t        keymap [MAP_DEPTH];
   map_entry_t        entry_c;

   logic [NB-1:0]     ks_work_q, ks_work_d, keystate_q;
   logic [NB-1:0]     raw_c, raw_q, cleaned_c, af_c;
   logic [PLAYERS*2-1:0][1:0] hist_q, hist_d;

   logic [CW-1:0]     af_cnt_q;
   logic              af_phase_q;

   logic              unused_joy;

   assign unused_joy = ^joy_i;

   // Register the PS/2 word and detect a change of the toggle bit
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         ps2_r    <= '0;
         tog_prev <= 1'b0;
      end else begin
         ps2_r    <= ps2_key;
         tog_prev <= ps2_r[10];
      end
   end

   assign event_c   = ps2_r[10] ^ tog_prev;
   assign new_evt_c = key_evt_t'(ps2_r[9:0]);
   assign last_c    = (idx_q == AW'(MAP_DEPTH - 1));
   assign entry_c   = keymap[idx_q];

   // FSM state register; busy mirrors the next state so it is a flop
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d == S_SCAN);
      end
   end

   // FSM next state: a scan chains straight into the next one when work is waiting
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (event_c) state_d = S_SCAN;
         S_SCAN:  if (last_c && !pend_valid_q && !event_c) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM control strobes for the event, pending and keystate registers
   always_comb begin
      start_new_c  = 1'b0;
      start_pend_c = 1'b0;
      pend_load_c  = 1'b0;
      pend_clr_c   = 1'b0;
      ovf_set_c    = 1'b0;
      commit_c     = 1'b0;
      scan_c       = 1'b0;
      case (state_q)
         S_IDLE: start_new_c = event_c;
         S_SCAN: begin
            scan_c   = 1'b1;
            commit_c = last_c;
            if (last_c) begin
               if (pend_valid_q) begin
                  start_pend_c = 1'b1;
                  pend_load_c  = event_c;
                  pend_clr_c   = !event_c;
               end else begin
                  start_new_c  = event_c;
               end
            end else if (event_c) begin
               pend_load_c = 1'b1;
               ovf_set_c   = pend_valid_q;
            end
         end
         default: ;
      endcase
   end

   // Scan index, active event, one-deep pending slot and sticky overflow
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         idx_q        <= '0;
         ev_q         <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         idx_q <= scan_c ? idx_q + AW'(1) : '0;
         if (start_new_c)       ev_q <= new_evt_c;
         else if (start_pend_c) ev_q <= pend_q;
         if (pend_load_c) begin
            pend_q       <= new_evt_c;
            pend_valid_q <= 1'b1;
         end else if (pend_clr_c) begin
            pend_valid_q <= 1'b0;
         end
         if (ovf_set_c) overflow <= 1'b1;
      end
   end

   // Runtime-writable keymap, restored to the factory table on reset
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         for (int unsigned i = 0; i < MAP_DEPTH; i++) keymap[i] <= default_entry(i);
      end else if (map_wr) begin
         keymap[map_addr] <= map_entry_t'(map_data);
      end
   end

   // Apply the scanned entry to the working keystate when it matches the event
   always_comb begin
      ks_work_d = ks_work_q;
      if (scan_c && entry_c.valid && entry_c.ext == ev_q.ext && entry_c.code == ev_q.code) begin
         for (int unsigned p = 0; p < PLAYERS; p++) begin
            for (int unsigned b = 0; b < BUTTONS; b++) begin
               if (32'(entry_c.player) == p && 32'(entry_c.button) == b)
                  ks_work_d[p*BUTTONS + b] = ev_q.pressed;
            end
         end
      end
   end

   // Working keystate per entry; visible keystate only changes at scan end
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         ks_work_q  <= '0;
         keystate_q <= '0;
      end else begin
         ks_work_q <= ks_work_d;
         if (commit_c) keystate_q <= ks_work_d;
      end
   end

   // Merge keyboard state with remapped joystick bits
   always_comb begin
      raw_c = keystate_q;
      for (int unsigned p = 0; p < PLAYERS; p++) begin
         for (int unsigned b = 0; b < BUTTONS; b++) begin
            raw_c[p*BUTTONS + b] = keystate_q[p*BUTTONS + b] | joy_bit(joy_i[p*32 +: 32], b);
         end
      end
   end

   // SOCD cleaning on (left,right) and (up,down), history tracks the latest 0->1 edge
   always_comb begin
      int unsigned ai, bi;
      logic        a_rise, b_rise;
      cleaned_c = raw_c;
      hist_d    = hist_q;
      ai        = 0;
      bi        = 0;
      a_rise    = 1'b0;
      b_rise    = 1'b0;
      for (int unsigned p = 0; p < PLAYERS; p++) begin
         for (int unsigned pr = 0; pr < 2; pr++) begin
            ai     = p*BUTTONS + ((pr == 0) ? 2 : 0);
            bi     = ai + 1;
            a_rise = raw_c[ai] & ~raw_q[ai];
            b_rise = raw_c[bi] & ~raw_q[bi];
            if (a_rise && b_rise) hist_d[p*2 + pr] = H_NONE;
            else if (a_rise)      hist_d[p*2 + pr] = H_A;
            else if (b_rise)      hist_d[p*2 + pr] = H_B;
            if (raw_c[ai] && raw_c[bi]) begin
               case (socd_mode)
                  2'd1: begin
                     cleaned_c[ai] = 1'b0;
                     cleaned_c[bi] = 1'b0;
                  end
                  2'd2: begin
                     cleaned_c[ai] = (hist_d[p*2 + pr] == H_A);
                     cleaned_c[bi] = (hist_d[p*2 + pr] == H_B);
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Gate autofire-enabled buttons with the global phase
   always_comb begin
      af_c = cleaned_c;
      for (int unsigned p = 0; p < PLAYERS; p++) begin
         for (int unsigned b = 0; b < BUTTONS; b++) begin
            af_c[p*BUTTONS + b] = cleaned_c[p*BUTTONS + b] & (~af_mask[b] | af_phase_q);
         end
      end
   end

   // Free-running autofire tick counter and phase
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         af_cnt_q   <= '0;
         af_phase_q <= 1'b1;
      end else if (af_tick) begin
         if (af_cnt_q == CW'(AF_PERIOD - 1)) begin
            af_cnt_q   <= '0;
            af_phase_q <= ~af_phase_q;
         end else begin
            af_cnt_q <= af_cnt_q + CW'(1);
         end
      end
   end

   // Output register plus the SOCD edge history
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         buttons_o <= '0;
         raw_q     <= '0;
         hist_q    <= '0;
      end else begin
         buttons_o <= af_c;
         raw_q     <= raw_c;
         hist_q    <= hist_d;
      end
   end

endmodule

// File: tb/tb_ps2_input_mapper.sv
// Directed testbench for ps2_input_mapper (2 players, 11 buttons, 32 entries, AF_PERIOD 2).
module tb_ps2_input_mapper;

   logic        clk_sys = 1'b0;
   logic        RESET   = 1'b1;
   logic [10:0] ps2_key = '0;
   logic [63:0] joy_i   = '0;
   logic        map_wr  = 1'b0;
   logic [4:0]  map_addr = '0;
   logic [15:0] map_data = '0;
   logic [1:0]  socd_mode = '0;
   logic [10:0] af_mask = '0;
   logic        af_tick = 1'b0;
   logic [21:0] buttons_o;
   logic        busy;
   logic        overflow;

   logic        tog = 1'b0;
   int          errors = 0;
   int          checks = 0;

   ps2_input_mapper #(
      .PLAYERS(2), .BUTTONS(11), .MAP_DEPTH(32), .AF_PERIOD(2)
   ) dut (
      .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key), .joy_i(joy_i),
      .map_wr(map_wr), .map_addr(map_addr), .map_data(map_data),
      .socd_mode(socd_mode), .af_mask(af_mask), .af_tick(af_tick),
      .buttons_o(buttons_o), .busy(busy), .overflow(overflow)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic step(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
      tog     = ~tog;
      ps2_key = {tog, pressed, ext, code};
   endtask

   task automatic write_map(input logic [4:0] addr, input logic [15:0] data);
      map_wr   = 1'b1;
      map_addr = addr;
      map_data = data;
      step(1);
      map_wr   = 1'b0;
   endtask

   task automatic do_reset();
      RESET     = 1'b1;
      ps2_key   = '0;
      tog       = 1'b0;
      joy_i     = '0;
      map_wr    = 1'b0;
      socd_mode = 2'd0;
      af_mask   = '0;
      af_tick   = 1'b0;
      step(2);
      RESET = 1'b0;
      step(2);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (buttons_o !== 22'h0) begin errors++; $display("FAIL reset_buttons: got %h want %h", buttons_o, 22'h0); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
   endtask

   task automatic test_latency();
      do_reset();
      send_key(1'b1, 1'b1, 8'h75);
      step(1);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL lat_busy_c0: got %b want 0", busy); end
      step(1);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy_c1: got %b want 1", busy); end
      step(31);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy_c32: got %b want 1", busy); end
      checks++;
      if (buttons_o !== 22'h0) begin errors++; $display("FAIL lat_btn_c32: got %h want %h", buttons_o, 22'h0); end
      step(1);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL lat_busy_c33: got %b want 0", busy); end
      checks++;
      if (buttons_o !== 22'h0) begin errors++; $display("FAIL lat_btn_c33: got %h want %h", buttons_o, 22'h0); end
      step(1);
      checks++;
      if (buttons_o !== 22'h1) begin errors++; $display("FAIL lat_btn_c34: got %h want %h", buttons_o, 22'h1); end
      send_key(1'b0, 1'b1, 8'h75);
      step(40);
      checks++;
      if (buttons_o !== 22'h0) begin errors++; $display("FAIL lat_release: got %h want %h", buttons_o, 22'h0); end
   endtask

   task automatic test_back_to_back();
      logic [21:0] exp;
      do_reset();
      send_key(1'b1, 1'b0, 8'h14);
      step(5);
      send_key(1'b1, 1'b0, 8'h1E);
      step(64);
      exp = 22'((1 << 4) | (1 << 18));
      checks++;
      if (buttons_o !== exp) begin errors++; $display("FAIL b2b_two_events: got %h want %h", buttons_o, exp); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_no_overflow: got %b want 0", overflow); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", busy); end
      send_key(1'b1, 1'b0, 8'h11);
      step(3);
      send_key(1'b1, 1'b0, 8'h29);
      step(3);
      send_key(1'b1, 1'b0, 8'h16);
      step(3);
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_overflow: got %b want 1", overflow); end
      step(80);
      exp = 22'((1 << 4) | (1 << 5) | (1 << 7) | (1 << 18));
      checks++;
      if (buttons_o !== exp) begin errors++; $display("FAIL b2b_last_pending: got %h want %h", buttons_o, exp); end
   endtask

   task automatic test_keymap_write();
      logic [21:0] exp;
      do_reset();
      write_map(5'd22, {1'b1, 1'b0, 8'h1C, 2'd0, 4'd6});
      send_key(1'b1, 1'b0, 8'h1C);
      step(40);
      exp = 22'((1 << 6) | (1 << 15));
      checks++;
      if (buttons_o !== exp) begin errors++; $display("FAIL map_dual: got %h want %h", buttons_o, exp); end
      send_key(1'b0, 1'b0, 8'h1C);
      step(40);
      checks++;
      if (buttons_o !== 22'h0) begin errors++; $display("FAIL map_release: got %h want %h", buttons_o, 22'h0); end
      write_map(5'd22, {1'b0, 1'b0, 8'h1C, 2'd0, 4'd6});
      send_key(1'b1, 1'b0, 8'h1C);
      step(40);
      exp = 22'(1 << 15);
      checks++;
      if (buttons_o !== exp) begin errors++; $display("FAIL map_invalid: got %h want %h", buttons_o, exp); end
   endtask

   task automatic test_socd();
      do_reset();
      socd_mode = 2'd1;
      joy_i     = {32'h0, 32'h3};
      step(2);
      checks++;
      if (buttons_o !== 22'h0) begin errors++; $display("FAIL socd_neutral_lr: got %h want %h", buttons_o, 22'h0); end
      socd_mode = 2'd0;
      step(2);
      checks++;
      if (buttons_o !== 22'hC) begin errors++; $display("FAIL socd_pass: got %h want %h", buttons_o, 22'hC); end
      socd_mode = 2'd1;
      joy_i     = {32'hC, 32'h0};
      step(2);
      checks++;
      if (buttons_o !== 22'h0) begin errors++; $display("FAIL socd_neutral_ud_p2: got %h want %h", buttons_o, 22'h0); end
      socd_mode = 2'd2;
      joy_i     = '0;
      step(2);
      joy_i = {32'h0, 32'h2};
      step(5);
      checks++;
      if (buttons_o !== 22'h4) begin errors++; $display("FAIL socd_lw_left: got %h want %h", buttons_o, 22'h4); end
      joy_i = {32'h0, 32'h3};
      step(2);
      checks++;
      if (buttons_o !== 22'h8) begin errors++; $display("FAIL socd_lw_right: got %h want %h", buttons_o, 22'h8); end
      joy_i = {32'h0, 32'h2};
      step(2);
      checks++;
      if (buttons_o !== 22'h4) begin errors++; $display("FAIL socd_lw_left_back: got %h want %h", buttons_o, 22'h4); end
      joy_i = '0;
      step(2);
      joy_i = {32'h0, 32'h3};
      step(2);
      checks++;
      if (buttons_o !== 22'h0) begin errors++; $display("FAIL socd_lw_tie: got %h want %h", buttons_o, 22'h0); end
      joy_i = {32'h0, 32'h2};
      step(2);
      checks++;
      if (buttons_o !== 22'h4) begin errors++; $display("FAIL socd_lw_tie_release: got %h want %h", buttons_o, 22'h4); end
   endtask

   task automatic test_autofire();
      logic [21:0] exp;
      logic        ph;
      do_reset();
      af_mask = 11'h010;
      joy_i   = {32'h0, 32'h30};
      step(2);
      checks++;
      if (buttons_o !== 22'h30) begin errors++; $display("FAIL af_initial: got %h want %h", buttons_o, 22'h30); end
      for (int k = 1; k <= 8; k++) begin
         af_tick = 1'b1;
         step(1);
         af_tick = 1'b0;
         step(9);
         ph  = (((k / 2) % 2) == 0);
         exp = ph ? 22'h30 : 22'h20;
         checks++;
         if (buttons_o !== exp) begin errors++; $display("FAIL af_tick%0d: got %h want %h", k, buttons_o, exp); end
      end
   endtask

   task automatic test_reset_mid_scan();
      do_reset();
      write_map(5'd0, 16'h0000);
      send_key(1'b1, 1'b1, 8'h75);
      step(40);
      checks++;
      if (buttons_o !== 22'h0) begin errors++; $display("FAIL rst_entry0_cleared: got %h want %h", buttons_o, 22'h0); end
      send_key(1'b1, 1'b0, 8'h14);
      step(40);
      checks++;
      if (buttons_o !== 22'h10) begin errors++; $display("FAIL rst_pre_b1: got %h want %h", buttons_o, 22'h10); end
      send_key(1'b1, 1'b0, 8'h11);
      step(3);
      send_key(1'b1, 1'b0, 8'h29);
      step(3);
      send_key(1'b1, 1'b0, 8'h16);
      step(5);
      checks++;
      if (busy !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL rst_pre_state: got busy=%b ovf=%b want 1 1", busy, overflow); end
      RESET   = 1'b1;
      ps2_key = '0;
      tog     = 1'b0;
      #1;
      checks++;
      if (buttons_o !== 22'h0) begin errors++; $display("FAIL rst_async_buttons: got %h want %h", buttons_o, 22'h0); end
      checks++;
      if (busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_async_flags: got busy=%b ovf=%b want 0 0", busy, overflow); end
      step(1);
      RESET = 1'b0;
      step(2);
      send_key(1'b1, 1'b1, 8'h75);
      step(40);
      checks++;
      if (buttons_o !== 22'h1) begin errors++; $display("FAIL rst_map_restored: got %h want %h", buttons_o, 22'h1); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_post_idle: got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_keymap_write();
      test_socd();
      test_autofire();
      test_reset_mid_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
